// File: rtl/sram_word_controller.sv
// -----------------------------------------------------------------------------
// sram_word_controller
//
// Converts one DATA_W-bit word request from the MEM stage into BEATS narrow
// SRAM accesses (BEATS = DATA_W / SRAM_DQ_W, least-significant part first).
// Each beat lasts WAIT_CYCLES+1 clock cycles. The byte address is relocated
// by BASE_ADDR and checked for range and alignment before any SRAM activity.
// The pipeline freezes on ~ready.
//
// Ports
//   clk         in     rising-edge clock
//   rst         in     asynchronous active-high reset
//   rd_en       in     read request, held until ready
//   wr_en       in     write request, takes priority over rd_en
//   address     in     32-bit byte address
//   write_data  in     DATA_W store value
//   ready       out    combinational; low while a request is pending/in flight
//   read_data   out    registered read result, valid in the DONE cycle
//   err         out    high for the single completion cycle of a rejected request
//   SRAM_DQ     inout  SRAM data bus, driven only during a write access
//   SRAM_ADDR   out    registered SRAM half-word address
//   SRAM_WE_N   out    registered active-low write strobe
// -----------------------------------------------------------------------------
module sram_word_controller #(
    parameter int          DATA_W      = 32,
    parameter int          SRAM_DQ_W   = 16,
    parameter int          ADDR_W      = 18,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [31:0]          address,
    input  logic [DATA_W-1:0]    write_data,
    output logic                 ready,
    output logic [DATA_W-1:0]    read_data,
    output logic                 err,
    inout  wire  [SRAM_DQ_W-1:0] SRAM_DQ,
    output logic [ADDR_W-1:0]    SRAM_ADDR,
    output logic                 SRAM_WE_N
);

    localparam int BEATS     = DATA_W / SRAM_DQ_W;
    localparam int BEAT_SH   = $clog2(BEATS);
    localparam int BYTE_SH   = $clog2(DATA_W / 8);
    localparam int BEAT_LEN  = WAIT_CYCLES + 1;
    localparam int BEAT_CW   = (BEATS > 1) ? BEAT_SH : 1;
    localparam int WAIT_CW   = (BEAT_LEN > 1) ? $clog2(BEAT_LEN) : 1;

    // Number of CPU words the SRAM can hold; a word index at or above this is out of range.
    localparam logic [32:0] WORD_LIMIT = 33'd1 << (ADDR_W - BEAT_SH);
    // Low offset bits that must be zero for a word-aligned access.
    localparam logic [31:0] ALIGN_MASK = (32'd1 << BYTE_SH) - 32'd1;
    localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(BEATS - 1);
    localparam logic [WAIT_CW-1:0] LAST_WAIT = WAIT_CW'(BEAT_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    // Registered state
    state_t                 state_q;
    logic                   is_write_q;
    logic [BEAT_CW-1:0]     beat_q;
    logic [WAIT_CW-1:0]     wait_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [DATA_W-1:0]      read_data_q;
    logic                   err_q;
    logic [ADDR_W-1:0]      sram_addr_q;
    logic                   we_n_q;
    logic                   dq_oe_q;
    logic [SRAM_DQ_W-1:0]   dq_out_q;

    // Decoded request
    logic                   req_s;
    logic [31:0]            offset_s;
    logic [31:0]            word_s;
    logic                   below_base_s;
    logic                   misaligned_s;
    logic                   out_of_range_s;
    logic                   reject_s;
    logic [ADDR_W-1:0]      start_addr_s;

    // Extract the SRAM-width slice of a word belonging to beat idx.
    function automatic logic [SRAM_DQ_W-1:0] beat_slice(
        input logic [DATA_W-1:0]  data,
        input logic [BEAT_CW-1:0] idx
    );
        beat_slice = data[idx*SRAM_DQ_W +: SRAM_DQ_W];
    endfunction

    // Replace the slice of a word belonging to beat idx with a freshly read half.
    function automatic logic [DATA_W-1:0] insert_beat(
        input logic [DATA_W-1:0]    data,
        input logic [BEAT_CW-1:0]   idx,
        input logic [SRAM_DQ_W-1:0] half
    );
        insert_beat = data;
        insert_beat[idx*SRAM_DQ_W +: SRAM_DQ_W] = half;
    endfunction

    // Relocate the byte address and evaluate the reject conditions.
    always_comb begin
        req_s          = rd_en | wr_en;
        below_base_s   = (address < BASE_ADDR);
        offset_s       = address - BASE_ADDR;
        misaligned_s   = ((offset_s & ALIGN_MASK) != 32'd0);
        word_s         = offset_s >> BYTE_SH;
        // Compare with one extra bit so WORD_LIMIT = 2^32 would still work.
        out_of_range_s = ({1'b0, word_s} >= WORD_LIMIT);
        reject_s       = below_base_s | misaligned_s | out_of_range_s;
        // Word index is already known to be in range when this is used.
        start_addr_s   = ADDR_W'(word_s << BEAT_SH);
    end

    // Transaction FSM: beat/wait sequencing and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            is_write_q  <= 1'b0;
            beat_q      <= {BEAT_CW{1'b0}};
            wait_q      <= {WAIT_CW{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            read_data_q <= {DATA_W{1'b0}};
            err_q       <= 1'b0;
            sram_addr_q <= {ADDR_W{1'b0}};
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= {SRAM_DQ_W{1'b0}};
        end else begin
            // err is a one-cycle pulse; only the IDLE->ERR transition raises it.
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_s && reject_s) begin
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                    end else if (req_s) begin
                        state_q     <= ST_ACCESS;
                        is_write_q  <= wr_en;
                        wdata_q     <= write_data;
                        beat_q      <= {BEAT_CW{1'b0}};
                        wait_q      <= {WAIT_CW{1'b0}};
                        sram_addr_q <= start_addr_s;
                        we_n_q      <= ~wr_en;
                        dq_oe_q     <= wr_en;
                        dq_out_q    <= write_data[SRAM_DQ_W-1:0];
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (wait_q == LAST_WAIT) begin
                        // Last cycle of the current beat.
                        wait_q <= {WAIT_CW{1'b0}};
                        if (!is_write_q) begin
                            read_data_q <= insert_beat(read_data_q, beat_q, SRAM_DQ);
                        end else begin
                            read_data_q <= read_data_q;
                        end
                        if (beat_q == LAST_BEAT) begin
                            state_q <= ST_DONE;
                            we_n_q  <= 1'b1;
                            dq_oe_q <= 1'b0;
                        end else begin
                            beat_q      <= beat_q + BEAT_CW'(1);
                            sram_addr_q <= sram_addr_q + ADDR_W'(1);
                            dq_out_q    <= beat_slice(wdata_q, beat_q + BEAT_CW'(1));
                        end
                    end else begin
                        wait_q <= wait_q + WAIT_CW'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                ST_ERR: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    we_n_q  <= 1'b1;
                    dq_oe_q <= 1'b0;
                end
            endcase
        end
    end

    // A new request in IDLE drops ready in the same cycle so the pipeline freezes at once.
    assign ready = ((state_q == ST_IDLE) && !req_s) ||
                   (state_q == ST_DONE) || (state_q == ST_ERR);

    assign read_data = read_data_q;
    assign err       = err_q;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_DQ   = dq_oe_q ? dq_out_q : {SRAM_DQ_W{1'bz}};

endmodule

// File: tb/tb_sram_word_controller.sv
module tb_sram_word_controller;

    localparam int BASE = 1024;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;

    // Clock generation
    always #5 clk = ~clk;

    // DUT1: default parameters (32-bit word, 16-bit SRAM, 1 wait state)
    logic        rd1, wr1;
    logic [31:0] addr1, wd1;
    wire         rdy1, err1, wen1;
    wire  [31:0] rdata1;
    wire  [15:0] dq1;
    wire  [17:0] sa1;

    sram_word_controller #(
        .DATA_W(32), .SRAM_DQ_W(16), .ADDR_W(18), .WAIT_CYCLES(1), .BASE_ADDR(32'd1024)
    ) dut1 (
        .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(addr1),
        .write_data(wd1), .ready(rdy1), .read_data(rdata1), .err(err1),
        .SRAM_DQ(dq1), .SRAM_ADDR(sa1), .SRAM_WE_N(wen1)
    );

    // DUT2: 64-bit word, no wait states
    logic        rd2, wr2;
    logic [31:0] addr2;
    logic [63:0] wd2;
    wire         rdy2, err2, wen2;
    wire  [63:0] rdata2;
    wire  [15:0] dq2;
    wire  [9:0]  sa2;

    sram_word_controller #(
        .DATA_W(64), .SRAM_DQ_W(16), .ADDR_W(10), .WAIT_CYCLES(0), .BASE_ADDR(32'd1024)
    ) dut2 (
        .clk(clk), .rst(rst), .rd_en(rd2), .wr_en(wr2), .address(addr2),
        .write_data(wd2), .ready(rdy2), .read_data(rdata2), .err(err2),
        .SRAM_DQ(dq2), .SRAM_ADDR(sa2), .SRAM_WE_N(wen2)
    );

    // SRAM devices: combinational read, write on rising edge while WE_N is low
    logic [15:0] mem1 [0:262143];
    logic [15:0] mem2 [0:1023];
    assign dq1 = wen1 ? mem1[sa1] : 16'bz;
    assign dq2 = wen2 ? mem2[sa2] : 16'bz;

    // SRAM storage update (cleared while mem_init is high)
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 262144; i++) mem1[i] <= 16'h0;
            for (int i = 0; i < 1024; i++) mem2[i] <= 16'h0;
        end else begin
            if (!wen1) mem1[sa1] <= dq1;
            if (!wen2) mem2[sa2] <= dq2;
        end
    end

    // Scoreboard entries: kind 0 read, 1 write, 2 reject, 3 write cut by reset
    typedef struct {
        int          kind;
        logic [63:0] rdata;
        int          base;
        logic [63:0] mem_exp;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [31:0] ref1 [int];
    logic [63:0] ref2 [int];
    logic [31:0] last1;
    logic [63:0] last2;

    int n_tests = 0;
    int n_fail  = 0;
    int low1 = 0, we1 = 0, low2 = 0, we2 = 0;

    // Reference address decode: base relocation, alignment and capacity rules
    function automatic bit decode(input logic [31:0] a, input int bytes, input int nwords,
                                  output int w);
        longint off;
        w = 0;
        if (a < 32'(BASE)) return 1'b0;
        off = longint'(a) - longint'(BASE);
        if ((off % bytes) != 0) return 1'b0;
        if ((off / bytes) >= nwords) return 1'b0;
        w = int'(off / bytes);
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT completes a transaction
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("rst_we_n1", {63'd0, wen1}, 64'd1);
            check("rst_ready1", {63'd0, rdy1}, 64'd1);
            check("rst_err1", {63'd0, err1}, 64'd0);
            check("rst_rdata1", {32'd0, rdata1}, 64'd0);
            check("rst_addr1", {46'd0, sa1}, 64'd0);
            check("rst_we_n2", {63'd0, wen2}, 64'd1);
            check("rst_rdata2", rdata2, 64'd0);
            if (low1 > 0) begin
                if (q1.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL abort1: no scoreboard entry");
                end else begin
                    e = q1.pop_front();
                    for (int b = 0; b < 2; b++)
                        check("abort_mem1", {48'd0, mem1[e.base+b]}, {48'd0, e.mem_exp[b*16 +: 16]});
                end
            end
            low1 = 0; we1 = 0; low2 = 0; we2 = 0;
        end else begin
            if (!rdy1) begin
                low1++;
                if (!wen1) we1++;
            end else if (low1 > 0) begin
                if (q1.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL done1: no scoreboard entry");
                end else begin
                    e = q1.pop_front();
                    check("err1", {63'd0, err1}, {63'd0, e.kind == 2});
                    check("latency1", 64'(low1), (e.kind == 2) ? 64'd1 : 64'd5);
                    check("we_cycles1", 64'(we1), (e.kind == 1) ? 64'd4 : 64'd0);
                    check("rdata1", {32'd0, rdata1}, e.rdata);
                    if (e.kind == 1)
                        for (int b = 0; b < 2; b++)
                            check("mem1", {48'd0, mem1[e.base+b]}, {48'd0, e.mem_exp[b*16 +: 16]});
                end
                low1 = 0; we1 = 0;
            end else begin
                check("idle_err1", {63'd0, err1}, 64'd0);
            end

            if (!rdy2) begin
                low2++;
                if (!wen2) we2++;
            end else if (low2 > 0) begin
                if (q2.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL done2: no scoreboard entry");
                end else begin
                    e = q2.pop_front();
                    check("err2", {63'd0, err2}, {63'd0, e.kind == 2});
                    check("latency2", 64'(low2), (e.kind == 2) ? 64'd1 : 64'd5);
                    check("we_cycles2", 64'(we2), (e.kind == 1) ? 64'd4 : 64'd0);
                    check("rdata2", rdata2, e.rdata);
                    if (e.kind == 1)
                        for (int b = 0; b < 4; b++)
                            check("mem2", {48'd0, mem2[e.base+b]}, {48'd0, e.mem_exp[b*16 +: 16]});
                end
                low2 = 0; we2 = 0;
            end
        end
    end

    // Issue one request to DUT1 and hold it until ready (called at posedge+1)
    task automatic do_req1(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   w;
        int   n;
        e.base = 0; e.mem_exp = 64'd0; e.kind = 0;
        if (!decode(a, 4, 131072, w)) begin
            e.kind = 2;
        end else if (wr) begin
            e.kind = 1; ref1[w] = wd; e.base = w * 2; e.mem_exp = {32'd0, wd};
        end else begin
            last1 = ref1.exists(w) ? ref1[w] : 32'd0;
        end
        e.rdata = {32'd0, last1};
        q1.push_back(e);
        rd1 = rd; wr1 = wr; addr1 = a; wd1 = wd;
        n = 0;
        do begin @(negedge clk); n++; end while (!rdy1 && n < 100);
        if (!rdy1) begin
            $display("FAIL timeout1: ready stuck low at address %h", a);
            $fatal(1, "timeout");
        end
        @(posedge clk); #1;
        rd1 = 1'b0; wr1 = 1'b0;
    endtask

    // Issue one request to DUT2 and hold it until ready (called at posedge+1)
    task automatic do_req2(input logic rd, input logic wr, input logic [31:0] a, input logic [63:0] wd);
        exp_t e;
        int   w;
        int   n;
        e.base = 0; e.mem_exp = 64'd0; e.kind = 0;
        if (!decode(a, 8, 256, w)) begin
            e.kind = 2;
        end else if (wr) begin
            e.kind = 1; ref2[w] = wd; e.base = w * 4; e.mem_exp = wd;
        end else begin
            last2 = ref2.exists(w) ? ref2[w] : 64'd0;
        end
        e.rdata = last2;
        q2.push_back(e);
        rd2 = rd; wr2 = wr; addr2 = a; wd2 = wd;
        n = 0;
        do begin @(negedge clk); n++; end while (!rdy2 && n < 100);
        if (!rdy2) begin
            $display("FAIL timeout2: ready stuck low at address %h", a);
            $fatal(1, "timeout");
        end
        @(posedge clk); #1;
        rd2 = 1'b0; wr2 = 1'b0;
    endtask

    // Write to word 6 of DUT1, reset during the first cycle of the second beat
    task automatic abort_write1(input logic [31:0] wd);
        exp_t        e;
        logic [31:0] old;
        old = ref1.exists(6) ? ref1[6] : 32'd0;
        ref1[6]   = {old[31:16], wd[15:0]};
        e.kind    = 3;
        e.base    = 12;
        e.mem_exp = {32'd0, ref1[6]};
        e.rdata   = 64'd0;
        q1.push_back(e);
        last1 = 32'd0;
        last2 = 64'd0;
        wr1 = 1'b1; addr1 = 32'd1048; wd1 = wd;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; wr1 = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Stimulus
    initial begin
        int          r, rw, gap;
        logic [31:0] a;
        rst = 1'b1; mem_init = 1'b1;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0; wd1 = 32'd0;
        rd2 = 1'b0; wr2 = 1'b0; addr2 = 32'd0; wd2 = 64'd0;
        last1 = 32'd0; last2 = 64'd0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0; mem_init = 1'b0;
        @(posedge clk); #1;

        // Directed cases on the default configuration
        do_req1(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
        do_req1(1'b1, 1'b0, 32'd1032, 32'h0);
        do_req1(1'b1, 1'b0, 32'd1000, 32'h0);
        do_req1(1'b0, 1'b1, 32'd1026, 32'h11112222);
        do_req1(1'b1, 1'b0, 32'd1024 + 32'd524288, 32'h0);
        do_req1(1'b1, 1'b1, 32'd1040, 32'h12345678);
        do_req1(1'b1, 1'b0, 32'd1040, 32'h0);
        do_req1(1'b0, 1'b1, 32'd1048, 32'hA5A5C3C3);
        abort_write1(32'h7777_9999);
        do_req1(1'b1, 1'b0, 32'd1048, 32'h0);

        // Randomized traffic, including boundary words and every reject class
        for (int i = 0; i < 40; i++) begin
            r  = int'($urandom_range(0, 9));
            rw = int'($urandom_range(0, 2));
            case (r)
                0:       a = $urandom_range(0, 1023);
                1:       a = 32'd1024 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(1, 3));
                2:       a = 32'd1024 + (32'd131072 + 32'($urandom_range(0, 3))) * 32'd4;
                3:       a = 32'd1024 + 32'd131071 * 32'd4;
                default: a = 32'd1024 + 32'($urandom_range(0, 15) * 4);
            endcase
            do_req1(rw != 1, rw != 0, a, $urandom);
            gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end

        // Wide configuration
        do_req2(1'b0, 1'b1, 32'd1024, 64'h0123456789ABCDEF);
        do_req2(1'b1, 1'b0, 32'd1024, 64'd0);
        do_req2(1'b1, 1'b0, 32'd1028, 64'd0);
        do_req2(1'b0, 1'b1, 32'd1024 + 32'd255 * 32'd8, {$urandom, $urandom});
        do_req2(1'b1, 1'b0, 32'd1024 + 32'd256 * 32'd8, 64'd0);
        for (int i = 0; i < 8; i++) begin
            a = 32'd1024 + 32'($urandom_range(0, 7) * 8);
            do_req2($urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0 ? 1'b0 : 1'b1, a,
                    {$urandom, $urandom});
        end
        do_req2(1'b1, 1'b0, 32'd1024 + 32'd255 * 32'd8, 64'd0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_word_controller.md
# sram_word_controller

Parametrised successor to the single-width SRAM controller on the MEM stage of the ARM pipeline. Converts one DATA_W-bit word request from the MEM stage into BEATS = DATA_W/SRAM_DQ_W narrow SRAM accesses. Each beat takes a configurable number of wait states. Base-address relocation and range/alignment checking are built in. `ready` drives the pipeline freeze (freeze = ~ready) exactly as the current controller does.

## Interface
- DATA_W, 32: CPU word width; multiple of SRAM_DQ_W; BEATS = DATA_W/SRAM_DQ_W is a power of 2.
- SRAM_DQ_W, 16: SRAM data bus width.
- ADDR_W, 18: SRAM address width; capacity 2^ADDR_W half-words, i.e. 2^ADDR_W/BEATS CPU words.
- WAIT_CYCLES, 1: extra hold cycles per beat; beat length L = WAIT_CYCLES+1.
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- rd_en  in  1  read request; held by the frozen pipeline until ready.
- wr_en  in  1  write request; wins if asserted together with rd_en.
- address  in  32  byte address from the ALU result.
- write_data  in  DATA_W  store value.
- ready  out  1  combinational; low while a request is pending or in progress.
- read_data  out  DATA_W  registered read result.
- err  out  1  high in the completion cycle of a rejected request.
- SRAM_DQ  inout  SRAM_DQ_W  bidirectional data bus.
- SRAM_ADDR  out  ADDR_W  registered SRAM address.
- SRAM_WE_N  out  1  registered active-low write strobe.

## Operation
- States: IDLE, ACCESS, DONE, ERR.
- ready = (IDLE & ~(rd_en|wr_en)) | DONE | ERR.
- Address mapping: off = address − BASE_ADDR. word = off >> log2(DATA_W/8). SRAM_ADDR for beat b = word*BEATS + b.
- Reject conditions: address < BASE_ADDR, off not aligned to DATA_W/8, or word ≥ 2^ADDR_W/BEATS.
- IDLE with request and reject condition true → ERR. No SRAM activity; read_data unchanged; err = 1 for that cycle only.
- IDLE with valid request → ACCESS. Latch the operation, word, and write_data; beat = 0; wait counter = 0; SRAM_ADDR = word*BEATS. SRAM_WE_N = 0 for a write.
- ACCESS, write: drive SRAM_DQ = write_data[b*SRAM_DQ_W +: SRAM_DQ_W] for every cycle of beat b. SRAM_WE_N stays low for all L cycles. Beats go least-significant half first.
- ACCESS, read: SRAM_DQ is high-Z. On the last cycle of beat b, capture SRAM_DQ into read_data[b*SRAM_DQ_W +: SRAM_DQ_W].
- Counters: the wait counter wraps at L and then increments beat. After the last cycle of beat BEATS−1 → DONE, with SRAM_WE_N = 1.
- DONE and ERR each last one cycle, then return to IDLE. A request seen in IDLE on the next cycle starts a new transaction; there is no request memory.
- SRAM_DQ is high-Z in every state except write ACCESS.
- The SRAM device reads combinationally from SRAM_ADDR and writes on the rising edge while SRAM_WE_N = 0.

## Timing
- Reset values: state IDLE; SRAM_WE_N = 1; SRAM_ADDR = 0; read_data = 0; err = 0; SRAM_DQ high-Z; counters 0.
- Valid request seen at cycle 0:
  - ready is low in cycles 0 … BEATS*L.
  - ready is high and read_data is valid in cycle BEATS*L+1 (DONE).
  - Defaults: ready low for 5 cycles, high in cycle 5.
- Rejected request: ready low in cycle 0, ready = err = 1 in cycle 1.
- rd_en/wr_en changing mid-ACCESS is ignored; the latched operation completes.
- Reset asserted mid-ACCESS:
  - Return to IDLE at once; SRAM_WE_N = 1 and DQ released.
  - A partially written word is left as written; no rollback.
- No request while idle: ready = 1 and outputs hold.

## Test plan
- Default parameters:
  - Write 0xDEADBEEF to 1032 → SRAM[4] = 0xBEEF, SRAM[5] = 0xDEAD.
  - SRAM_WE_N low for exactly 4 cycles; ready high 5 cycles after the request.
- Read 1032 after the write above → read_data = 0xDEADBEEF in the DONE cycle. err = 0; DQ never driven by the controller.
- Rejects, each giving err = ready = 1 one cycle after the request, no SRAM_WE_N pulse, and read_data unchanged:
  - address 1000 (below BASE_ADDR);
  - address 1026 (misaligned);
  - address 1024+524288 (out of range).
- Both rd_en and wr_en asserted at 1040 with write_data 0x12345678 → write performed; SRAM[8] = 0x5678, SRAM[9] = 0x1234.
- Reset pulse during the second beat of a write → SRAM_WE_N = 1 and DQ high-Z immediately. Next request starts cleanly from IDLE.
- DATA_W=64, WAIT_CYCLES=0: write 0x0123456789ABCDEF to 1024 → SRAM[0..3] = 0xCDEF, 0x89AB, 0x4567, 0x0123. ready low for 5 cycles; read back matches.
